q_regulator_mc: RTL and testbench

Multi-channel charge regulator: successor to the single-channel measurement/bisection/instability/setup-complete chain. It counts serialized charge pulses on N_CH channels over a common measurement window and converts each count to charge. A shared, time-multiplexed bisection engine searches each channel's current reference, reports lock and failure, and watches locked channels for instability. It sits between the per-channel pulse front-ends and the current-reference DACs.

---
 rtl/q_reg_pkg.sv | 38 +++
 rtl/q_pulse_counter.sv | 49 ++++
 rtl/q_regulator_mc.sv | 252 +++++++++++++++++++++++++
 tb/tb_q_regulator_mc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_reg_pkg.sv
// Shared types and width helpers for the multi-channel charge regulator.
// Holds the top FSM state enum, channel mode enum and derived widths.
package q_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_UPDATE  = 2'd2
  } q_state_e;

  typedef enum logic [1:0] {
    M_SEARCH = 2'd0,
    M_LOCKED = 2'd1,
    M_FAILED = 2'd2
  } ch_mode_e;

  localparam int DEF_BUS_WIDTH = 10;
  localparam int DEF_WINDOW    = 64;
  localparam int DEF_MAX_ITER  = DEF_BUS_WIDTH + 2;

  // Rising edges in a window of w cycles never exceed w/2 (+1 values).
  function automatic int q_cnt_w(input int w);
    return (w / 2 + 1) > 2 ? $clog2(w / 2 + 1) : 1;
  endfunction

  function automatic int q_iter_w(input int max_iter);
    return (max_iter + 1) > 2 ? $clog2(max_iter + 1) : 1;
  endfunction

  function automatic int q_err_w(input int bw);
    return bw + 1;
  endfunction

  localparam int CNT_W  = q_cnt_w(DEF_WINDOW);
  localparam int ITER_W = q_iter_w(DEF_MAX_ITER);
  localparam int ERR_W  = q_err_w(DEF_BUS_WIDTH);

endpackage

// File: rtl/q_pulse_counter.sv
// Per-channel pulse counter: rising-edge detect, clear/freeze, saturating charge.
// Ports: clk, rst (sync, active-low), i_clr, i_en, i_q -> o_q_meas.
module q_pulse_counter
  import q_reg_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int WINDOW_CYCLES = 64,
  parameter int Q_PER_PULSE   = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_q,
  output logic [BUS_WIDTH-1:0] o_q_meas
);

  localparam int CW = q_cnt_w(WINDOW_CYCLES);
  localparam logic [BUS_WIDTH-1:0] QMAX = '1;

  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          w_edge;
  logic [31:0]   w_prod;

  assign w_edge = i_q & ~r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_q;
      if (i_clr)
        r_cnt <= '0;
      else if (i_en && w_edge && (r_cnt != '1))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_prod = 32'(r_cnt) * 32'(Q_PER_PULSE);

  always_comb begin
    o_q_meas = w_prod[BUS_WIDTH-1:0];
    if (w_prod > 32'(QMAX))
      o_q_meas = QMAX;
  end

endmodule

// File: rtl/q_regulator_mc.sv
// Multi-channel charge regulator: per-channel pulse counting plus a shared,
// time-multiplexed bisection search of each channel's current reference.
// Ports: clk, rst (sync, active-low), start, q_serialized[N_CH],
//   q_desired[N_CH*BW] -> i_ref_out[N_CH*BW], locked, failed, unstable,
//   all_settled, busy.
// Option: define Q_REG_RELOCK_EN to re-search around i_ref on instability.
module q_regulator_mc
  import q_reg_pkg::*;
#(
  parameter int BUS_WIDTH         = 10,
  parameter int N_CH              = 4,
  parameter int WINDOW_CYCLES     = 64,
  parameter int Q_PER_PULSE       = 30,
  parameter int TOL               = 1,
  parameter int MAX_ITER          = BUS_WIDTH + 2,
  parameter int DELTA_Q_INSTB     = 50,
  parameter int I_REF_DELTA_INSTB = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_CH-1:0]           q_serialized,
  input  logic [N_CH*BUS_WIDTH-1:0] q_desired,
  output logic [N_CH*BUS_WIDTH-1:0] i_ref_out,
  output logic [N_CH-1:0]           locked,
  output logic [N_CH-1:0]           failed,
  output logic [N_CH-1:0]           unstable,
  output logic                      all_settled,
  output logic                      busy
);

  localparam int EW  = q_err_w(BUS_WIDTH);
  localparam int IW  = q_iter_w(MAX_ITER);
  localparam int WW  = WINDOW_CYCLES > 2 ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1;

  typedef logic [BUS_WIDTH-1:0] bus_t;
  typedef logic [EW-1:0]        ext_t;

  localparam ext_t HMAX  = ext_t'((1 << BUS_WIDTH) - 1);
  localparam bus_t IINIT = bus_t'(HMAX >> 1);

  q_state_e         r_state;
  logic [WW-1:0]    r_wcnt;
  logic [CHW-1:0]   r_ucnt;
  ext_t             r_lo   [N_CH];
  ext_t             r_hi   [N_CH];
  logic [IW-1:0]    r_iter [N_CH];
  ch_mode_e         r_mode [N_CH];
  bus_t             r_iref [N_CH];
  logic [N_CH-1:0]  r_unst;

  logic             w_meas;
  logic             w_upd;
  logic             w_last_w;
  logic             w_last_ch;
  logic             w_clr;
  bus_t             w_qm   [N_CH];

  assign w_meas    = (r_state == ST_MEASURE);
  assign w_upd     = (r_state == ST_UPDATE);
  assign w_last_w  = (r_wcnt == WW'(WINDOW_CYCLES - 1));
  assign w_last_ch = (r_ucnt == CHW'(N_CH - 1));
  assign w_clr     = start | (w_upd & w_last_ch);

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    q_pulse_counter #(
      .BUS_WIDTH     (BUS_WIDTH),
      .WINDOW_CYCLES (WINDOW_CYCLES),
      .Q_PER_PULSE   (Q_PER_PULSE)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_en     (w_meas),
      .i_q      (q_serialized[g]),
      .o_q_meas (w_qm[g])
    );
  end

  // Selected channel operands for the shared datapath.
  bus_t              w_qm_s;
  bus_t              w_qd_s;
  bus_t              w_iref_s;
  ext_t              w_iref_x;
  ext_t              w_lo_s;
  ext_t              w_hi_s;
  logic [IW-1:0]     w_iter_s;
  ch_mode_e          w_mode_s;
  logic signed [EW-1:0] w_err;
  ext_t              w_abs;
  logic              w_tol;
  logic              w_instb;
  logic              w_exhaust;

  always_comb begin
    w_qm_s    = w_qm[r_ucnt];
    w_qd_s    = q_desired[r_ucnt*BUS_WIDTH +: BUS_WIDTH];
    w_iref_s  = r_iref[r_ucnt];
    w_iref_x  = {1'b0, w_iref_s};
    w_lo_s    = r_lo[r_ucnt];
    w_hi_s    = r_hi[r_ucnt];
    w_iter_s  = r_iter[r_ucnt];
    w_mode_s  = r_mode[r_ucnt];
    w_err     = $signed({1'b0, w_qm_s}) - $signed({1'b0, w_qd_s});
    w_abs     = w_err[EW-1] ? ext_t'(-w_err) : ext_t'(w_err);
    w_tol     = (w_abs <= ext_t'(TOL));
    w_instb   = (w_abs > ext_t'(DELTA_Q_INSTB));
    w_exhaust = ((32'(w_iter_s) + 32'd1) == 32'(MAX_ITER));
  end

  // Bisection step; i_ref==0 with err>0 has nowhere to go, so fail.
  ext_t w_lo_n;
  ext_t w_hi_n;
  logic w_force;

  always_comb begin
    w_lo_n  = w_lo_s;
    w_hi_n  = w_hi_s;
    w_force = 1'b0;
    if (w_err[EW-1])
      w_lo_n = w_iref_x + ext_t'(1);
    else if (w_iref_s == '0) begin
      w_hi_n  = '0;
      w_force = 1'b1;
    end else
      w_hi_n = w_iref_x - ext_t'(1);
  end

`ifdef Q_REG_RELOCK_EN
  ext_t w_lo_r;
  ext_t w_hi_r;

  always_comb begin
    w_lo_r = '0;
    if (w_iref_x >= ext_t'(I_REF_DELTA_INSTB))
      w_lo_r = w_iref_x - ext_t'(I_REF_DELTA_INSTB);
    w_hi_r = w_iref_x + ext_t'(I_REF_DELTA_INSTB);
    if (w_hi_r > HMAX)
      w_hi_r = HMAX;
  end
`endif

  ext_t          w_lo_w;
  ext_t          w_hi_w;
  logic [IW-1:0] w_iter_n;
  ch_mode_e      w_mode_n;
  bus_t          w_iref_n;
  logic          w_unst_n;

  always_comb begin
    w_lo_w   = w_lo_s;
    w_hi_w   = w_hi_s;
    w_iter_n = w_iter_s;
    w_mode_n = w_mode_s;
    w_iref_n = w_iref_s;
    w_unst_n = r_unst[r_ucnt];
    unique case (1'b1)
      (w_mode_s == M_SEARCH): begin
        if (w_tol)
          w_mode_n = M_LOCKED;
        else begin
          w_lo_w = w_lo_n;
          w_hi_w = w_hi_n;
          if (w_force || (w_lo_n > w_hi_n) || w_exhaust)
            w_mode_n = M_FAILED;
          else begin
            w_iref_n = bus_t'((w_lo_n + w_hi_n) >> 1);
            w_iter_n = w_iter_s + IW'(1);
          end
        end
      end
      (w_mode_s == M_LOCKED): begin
        if (w_instb) begin
          w_unst_n = 1'b1;
`ifdef Q_REG_RELOCK_EN
          w_mode_n = M_SEARCH;
          w_lo_w   = w_lo_r;
          w_hi_w   = w_hi_r;
          w_iter_n = '0;
          w_iref_n = bus_t'((w_lo_r + w_hi_r) >> 1);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_ucnt  <= '0;
      r_unst  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_lo[i]   <= '0;
        r_hi[i]   <= '0;
        r_iter[i] <= '0;
        r_mode[i] <= M_SEARCH;
        r_iref[i] <= '0;
      end
    end else if (start) begin
      r_state <= ST_MEASURE;
      r_wcnt  <= '0;
      r_ucnt  <= '0;
      r_unst  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_lo[i]   <= '0;
        r_hi[i]   <= HMAX;
        r_iter[i] <= '0;
        r_mode[i] <= M_SEARCH;
        r_iref[i] <= IINIT;
      end
    end else begin
      unique case (1'b1)
        w_meas: begin
          if (w_last_w) begin
            r_state <= ST_UPDATE;
            r_ucnt  <= '0;
          end else
            r_wcnt <= r_wcnt + WW'(1);
        end
        w_upd: begin
          r_lo[r_ucnt]   <= w_lo_w;
          r_hi[r_ucnt]   <= w_hi_w;
          r_iter[r_ucnt] <= w_iter_n;
          r_mode[r_ucnt] <= w_mode_n;
          r_iref[r_ucnt] <= w_iref_n;
          r_unst[r_ucnt] <= w_unst_n;
          if (w_last_ch) begin
            r_state <= ST_MEASURE;
            r_wcnt  <= '0;
            r_ucnt  <= '0;
          end else
            r_ucnt <= r_ucnt + CHW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign i_ref_out[g*BUS_WIDTH +: BUS_WIDTH] = r_iref[g];
    assign locked[g] = (r_mode[g] == M_LOCKED);
    assign failed[g] = (r_mode[g] == M_FAILED);
  end

  assign unstable    = r_unst;
  assign all_settled = &(locked | failed);
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_q_regulator_mc.sv
// Directed + randomized bench for q_regulator_mc with a behavioural model.
// Plant emits floor(i_ref/div) pulses per window; model tracks expectations.
module tb_q_regulator_mc;

  localparam int BW    = 10;
  localparam int NCH   = 2;
  // Window long enough to carry 40 pulses for the saturation case.
  localparam int WIN   = 96;
  localparam int QPP   = 30;
  localparam int TOLV  = 1;
  localparam int MAXIT = BW + 2;
  localparam int DQ    = 50;
  localparam int DI    = 10;
  localparam int QMAX  = 1023;
  localparam int SRCH  = 0;
  localparam int LCK   = 1;
  localparam int FLD   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [NCH-1:0]      q_ser = '0;
  logic [NCH*BW-1:0]   q_des = '0;
  logic [NCH*BW-1:0]   i_ref_out;
  logic [NCH-1:0]      locked;
  logic [NCH-1:0]      failed;
  logic [NCH-1:0]      unstable;
  logic                all_settled;
  logic                busy;

  always #5 clk = ~clk;

  q_regulator_mc #(
    .BUS_WIDTH     (BW),
    .N_CH          (NCH),
    .WINDOW_CYCLES (WIN),
    .Q_PER_PULSE   (QPP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .q_serialized (q_ser),
    .q_desired    (q_des),
    .i_ref_out    (i_ref_out),
    .locked       (locked),
    .failed       (failed),
    .unstable     (unstable),
    .all_settled  (all_settled),
    .busy         (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_lo[NCH], m_hi[NCH], m_it[NCH], m_mode[NCH];
  int m_iref[NCH], m_uns[NCH], qd[NCH], dv[NCH];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_iref(input int ch);
    return int'(i_ref_out[ch*BW +: BW]);
  endfunction

  function automatic bit model_settled();
    for (int c = 0; c < NCH; c++)
      if (m_mode[c] == SRCH) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_start();
    for (int c = 0; c < NCH; c++) begin
      m_lo[c] = 0;
      m_hi[c] = QMAX;
      m_it[c] = 0;
      m_mode[c] = SRCH;
      m_iref[c] = QMAX / 2;
      m_uns[c] = 0;
    end
  endtask

  task automatic model_update(input int c, input int n);
    int qm, err, ae;
    bit forced;
    qm = n * QPP;
    if (qm > QMAX) qm = QMAX;
    err = qm - qd[c];
    ae = err < 0 ? -err : err;
    forced = 1'b0;
    if (m_mode[c] == SRCH) begin
      if (ae <= TOLV) m_mode[c] = LCK;
      else begin
        if (err < 0) m_lo[c] = m_iref[c] + 1;
        else if (m_iref[c] == 0) begin
          m_hi[c] = 0;
          forced = 1'b1;
        end else m_hi[c] = m_iref[c] - 1;
        if (forced || m_lo[c] > m_hi[c] || m_it[c] + 1 == MAXIT)
          m_mode[c] = FLD;
        else begin
          m_iref[c] = (m_lo[c] + m_hi[c]) / 2;
          m_it[c]++;
        end
      end
    end else if (m_mode[c] == LCK && ae > DQ) begin
      m_uns[c] = 1;
`ifdef Q_REG_RELOCK_EN
      m_lo[c] = m_iref[c] - DI < 0 ? 0 : m_iref[c] - DI;
      m_hi[c] = m_iref[c] + DI > QMAX ? QMAX : m_iref[c] + DI;
      m_it[c] = 0;
      m_mode[c] = SRCH;
      m_iref[c] = (m_lo[c] + m_hi[c]) / 2;
`endif
    end
  endtask

  task automatic check_ch(input string tag, input int c);
    chk($sformatf("%s_iref%0d", tag, c), get_iref(c), m_iref[c]);
    chk($sformatf("%s_lock%0d", tag, c), int'(locked[c]), int'(m_mode[c] == LCK));
    chk($sformatf("%s_fail%0d", tag, c), int'(failed[c]), int'(m_mode[c] == FLD));
    chk($sformatf("%s_unst%0d", tag, c), int'(unstable[c]), m_uns[c]);
  endtask

  task automatic do_start();
    for (int c = 0; c < NCH; c++) q_des[c*BW +: BW] = BW'(qd[c]);
    q_ser = '0;
    start = 1'b1;
    model_start();
    tick();
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    for (int c = 0; c < NCH; c++) check_ch("start", c);
  endtask

  task automatic run_pass(input int ovr0, input bit start_last);
    int n[NCH];
    for (int c = 0; c < NCH; c++) begin
      n[c] = m_iref[c] / dv[c];
      if (n[c] > WIN / 2) n[c] = WIN / 2;
    end
    if (ovr0 >= 0) n[0] = ovr0;
    for (int j = 0; j < WIN; j++) begin
      for (int c = 0; c < NCH; c++)
        q_ser[c] = (j % 2 == 0) && (j / 2 < n[c]);
      tick();
    end
    for (int k = 0; k < NCH; k++) begin
      // A pulse during UPDATE must not be counted.
      q_ser = (k == 0) ? '1 : '0;
      if (start_last && k == NCH - 1) start = 1'b1;
      tick();
      if (start_last && k == NCH - 1) begin
        start = 1'b0;
        model_start();
        for (int c = 0; c < NCH; c++) check_ch("restart", c);
      end else begin
        model_update(k, n[k]);
        check_ch("upd", k);
      end
    end
    q_ser = '0;
    chk("pass_busy", int'(busy), 1);
    chk("pass_settled", int'(all_settled), int'(model_settled()));
  endtask

  task automatic run_until_settled();
    for (int p = 0; p < 16 && !model_settled(); p++) run_pass(-1, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_iref"}, int'(i_ref_out), 0);
    chk({tag, "_lock"}, int'(locked), 0);
    chk({tag, "_fail"}, int'(failed), 0);
    chk({tag, "_unst"}, int'(unstable), 0);
    chk({tag, "_settled"}, int'(all_settled), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  int exp_seq[5] = '{255, 383, 319, 351, 351};

  initial begin
    for (int c = 0; c < NCH; c++) begin
      qd[c] = 0;
      dv[c] = 32;
    end
    model_start();

    // Reset state.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_reset("rst");

    // Nominal lock on channel 0.
    qd[0] = 300;
    qd[1] = int'($urandom_range(0, 930));
    do_start();
    chk("nom_init", get_iref(0), 511);
    for (int p = 0; p < 5; p++) begin
      run_pass(-1, 1'b0);
      chk($sformatf("nom_seq%0d", p), get_iref(0), exp_seq[p]);
    end
    chk("nom_locked", int'(locked[0]), 1);
    run_until_settled();
    chk("nom_all_settled", int'(all_settled), 1);

    // Instability after lock.
    dv[0] = 16;
    run_pass(-1, 1'b0);
    chk("inst_unst", int'(unstable[0]), 1);
    chk("inst_iref", get_iref(0), 351);
`ifdef Q_REG_RELOCK_EN
    chk("inst_locked", int'(locked[0]), 0);
`else
    chk("inst_locked", int'(locked[0]), 1);
`endif

    // Restart on the last UPDATE cycle.
    run_pass(-1, 1'b1);
    chk("rs_iref0", get_iref(0), 511);
    chk("rs_iref1", get_iref(1), 511);
    chk("rs_unst", int'(unstable), 0);
    dv[0] = 32;
    run_pass(-1, 1'b0);

    // Saturating measurement.
    qd[0] = 500;
    do_start();
    run_pass(40, 1'b0);
    chk("sat_iref", get_iref(0), 255);

    // Failure via empty range.
    qd[0] = 15;
    do_start();
    run_until_settled();
    chk("fail_failed", int'(failed[0]), 1);
    chk("fail_locked", int'(locked[0]), 0);
    chk("fail_iref", get_iref(0), 32);

    // Reset mid-MEASURE.
    do_start();
    for (int j = 0; j < 20; j++) begin
      q_ser = (j % 2 == 0) ? '1 : '0;
      tick();
    end
    q_ser = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset("mrst");
    for (int j = 0; j < 150; j++) begin
      q_ser = NCH'($urandom);
      tick();
    end
    q_ser = '0;
    check_reset("idle");
    do_start();
    run_pass(-1, 1'b0);

    // Randomized targets.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NCH; c++) begin
        qd[c] = int'($urandom_range(0, QMAX));
        dv[c] = ($urandom_range(0, 1) == 0) ? 32 : 16;
      end
      do_start();
      run_until_settled();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
